// File: rtl/mem_bus_pkg.sv
// Shared definitions for word-wide bus responders: widths, FSM states and the
// access-legality check applied when a request is captured.
package mem_bus_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BE_W       = 4;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Misaligned byte address, or word index beyond the backing store.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned       depth_words);
        return (addr[1:0] != 2'b00) || (32'(addr[WORD_W-1:2]) >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read
// port (data appears the cycle after the address is presented).
module dmem_bank
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned k = 0; k < BE_W; k++) begin
                if (be_i[k]) begin
                    mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Target side of the data-memory req/ack handshake: captures one request,
// waits WAIT_CYC cycles, then acks with read data or an error flag.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYC    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  capture;
    logic                  we_q;
    logic                  err_q;
    logic [AW-1:0]         widx_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [BE_W-1:0]       be_q;
    logic [WORD_W-1:0]     rdata_q;
    logic [WORD_W-1:0]     bank_rdata;
    logic [WORD_W-1:0]     resp_data;
    logic [AW-1:0]         raddr;
    logic                  bank_we;
    logic                  rdata_upd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_CNT_W'(WAIT_CYC);
                    state_d = (WAIT_CYC == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q == WAIT_CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the read follows the live address so a zero-wait load still has
    // its data registered by RESP; afterwards it follows the captured index.
    assign raddr     = (state_q == IDLE) ? addr_i[AW+1:2] : widx_q;
    assign bank_we   = (state_q == RESP) && we_q && !err_q;
    assign resp_data = err_q ? '0 : bank_rdata;
    assign rdata_upd = (state_q == RESP) && (err_q || !we_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= we_i;
                err_q   <= addr_err(addr_i, DEPTH_WORDS);
                widx_q  <= addr_i[AW+1:2];
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            if (rdata_upd) begin
                rdata_q <= resp_data;
            end
        end
    end

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk     (clk),
        .we_i    (bank_we),
        .be_i    (be_q),
        .waddr_i (widx_q),
        .wdata_i (wdata_q),
        .raddr_i (raddr),
        .rdata_o (bank_rdata)
    );

    assign ack_o   = (state_q == RESP);
    assign err_o   = ack_o && err_q;
    assign busy_o  = (state_q != IDLE);
    assign rdata_o = rdata_upd ? resp_data : rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) checked every
// cycle against a transaction-level memory/timing model.
module tb_mem_responder;

    localparam int unsigned W0 = 2;
    localparam int unsigned W1 = 0;
    localparam int unsigned D0 = 1024;
    localparam int unsigned D1 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];

    logic        ack0, ack1, err0, err1, busy0, busy1;
    logic [31:0] rdata0, rdata1;

    mem_responder #(.DEPTH_WORDS(D0), .WAIT_CYC(W0)) u_w2 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .be_i(be[0]), .ack_o(ack0), .rdata_o(rdata0),
        .err_o(err0), .busy_o(busy0)
    );

    mem_responder #(.DEPTH_WORDS(D1), .WAIT_CYC(W1)) u_w0 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .be_i(be[1]), .ack_o(ack1), .rdata_o(rdata1),
        .err_o(err1), .busy_o(busy1)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: memory image plus the cycle numbers of the current
    // request's capture and ack for each instance.
    logic [31:0] mem      [2][1024];
    int          cap_cyc  [2];
    int          ack_cyc  [2];
    bit          exp_err  [2];
    bit          exp_load [2];
    logic [31:0] exp_data [2];
    logic [31:0] held     [2];

    function automatic int depth_of(input int d);
        return (d == 0) ? int'(D0) : int'(D1);
    endfunction

    function automatic int wcyc(input int d);
        return (d == 0) ? int'(W0) : int'(W1);
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, cyc, act, exp);
        end
    endtask

    logic        c_ack, c_err, c_busy, c_resp;
    logic [31:0] c_rd;
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            c_ack  = (d == 0) ? ack0   : ack1;
            c_err  = (d == 0) ? err0   : err1;
            c_busy = (d == 0) ? busy0  : busy1;
            c_rd   = (d == 0) ? rdata0 : rdata1;
            if (rst) begin
                held[d] = '0;
                chk("rst_ack", d, c_ack, 0);
                chk("rst_err", d, c_err, 0);
                chk("rst_busy", d, c_busy, 0);
                chk("rst_rdata", d, c_rd, 0);
            end else begin
                c_resp = (cyc == ack_cyc[d]);
                if (c_resp && (exp_load[d] || exp_err[d]))
                    held[d] = exp_err[d] ? 32'h0 : exp_data[d];
                chk("ack", d, c_ack, c_resp);
                chk("busy", d, c_busy, (cyc >= cap_cyc[d]) && (cyc <= ack_cyc[d]));
                chk("err", d, c_err, c_resp && exp_err[d]);
                chk("rdata", d, c_rd, held[d]);
            end
        end
    end

    // Called at a negedge. Capture happens at the next edge the responder is
    // idle: no earlier than two edges after the previous ack.
    task automatic xact(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        input bit keep, input bit scribble,
                        output logic [31:0] rd, output logic e, output logic acked);
        int cap;
        bit er;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        er  = (a % 4 != 0) || (a / 4 >= 32'(depth_of(d)));
        cap = (cyc + 1 > ack_cyc[d] + 2) ? cyc + 1 : ack_cyc[d] + 2;
        if (!w && !er) exp_data[d] = mem[d][a / 4];
        if (w && !er)
            for (int k = 0; k < 4; k++)
                if (b[k]) mem[d][a / 4][8*k +: 8] = wd[8*k +: 8];
        exp_err[d]  = er;
        exp_load[d] = !w;
        cap_cyc[d]  = cap;
        ack_cyc[d]  = cap + wcyc(d);
        while (cyc < ack_cyc[d]) begin
            @(negedge clk);
            if (scribble && cyc >= cap && cyc < ack_cyc[d]) begin
                we[d] = 1'($urandom); addr[d] = $urandom;
                wdata[d] = $urandom; be[d] = 4'($urandom);
            end
        end
        acked = (d == 0) ? ack0 : ack1;
        rd    = (d == 0) ? rdata0 : rdata1;
        e     = (d == 0) ? err0 : err1;
        if (!keep) req[d] = 1'b0;
    endtask

    logic [31:0] rd, prior;
    logic        e, ak;
    int          c0, c1, cap;
    bit          keep, pend;
    int          dsel, r;
    logic [31:0] ra;

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; we[d] = 0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
            cap_cyc[d] = -10; ack_cyc[d] = -10; exp_err[d] = 0; exp_load[d] = 0;
            exp_data[d] = '0; held[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) xact(0, 1, 32'(i * 4), $urandom, 4'hF, 0, 0, rd, e, ak);
        for (int i = 0; i < 16; i++) xact(1, 1, 32'(i * 4), $urandom, 4'hF, 0, 0, rd, e, ak);
        @(negedge clk);

        // Store from idle: captured at the next edge, ack two cycles after that.
        c0 = cyc;
        xact(0, 1, 32'h40, 32'h1234_5678, 4'hF, 0, 0, rd, e, ak);
        chk("st_ack", 0, ak, 1);
        chk("st_err", 0, e, 0);
        chk("st_latency", 0, cyc - c0, 3);
        xact(0, 0, 32'h40, '0, 4'h0, 0, 0, rd, e, ak);
        chk("ld_full", 0, rd, 32'h1234_5678);

        xact(0, 1, 32'h40, 32'hAABB_CCDD, 4'b0101, 0, 0, rd, e, ak);
        xact(0, 0, 32'h40, '0, 4'h0, 0, 0, rd, e, ak);
        chk("ld_be0101", 0, rd, 32'h12BB_56DD);
        xact(0, 1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 0, 0, rd, e, ak);
        chk("st_be0_err", 0, e, 0);
        xact(0, 0, 32'h40, '0, 4'h0, 0, 0, rd, e, ak);
        chk("ld_after_be0", 0, rd, 32'h12BB_56DD);

        xact(0, 0, 32'h42, '0, 4'h0, 0, 0, rd, e, ak);
        chk("misalign_err", 0, e, 1);
        chk("misalign_rdata", 0, rd, 32'h0);
        prior = mem[0][0];
        xact(0, 1, 32'(4 * D0), ~prior, 4'hF, 0, 0, rd, e, ak);
        chk("range_err", 0, e, 1);
        xact(0, 0, 32'h0, '0, 4'h0, 0, 0, rd, e, ak);
        chk("no_alias", 0, rd, prior);

        // Field changes after capture must not affect the response.
        xact(0, 0, 32'h40, '0, 4'h0, 0, 1, rd, e, ak);
        chk("stable_fields", 0, rd, 32'h12BB_56DD);

        // Reset in the middle of a store's wait: no write, no ack.
        prior = mem[0][4];
        @(negedge clk);
        req[0] = 1; we[0] = 1; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF; be[0] = 4'hF;
        cap = cyc + 1;
        cap_cyc[0] = cap; ack_cyc[0] = cap + wcyc(0); exp_err[0] = 0; exp_load[0] = 0;
        @(negedge clk);
        rst = 1'b1; req[0] = 0;
        cap_cyc[0] = -10; ack_cyc[0] = -10; cap_cyc[1] = -10; ack_cyc[1] = -10;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        xact(0, 0, 32'h10, '0, 4'h0, 0, 0, rd, e, ak);
        chk("rst_no_write", 0, rd, prior);

        // Zero-wait instance, request held across two loads.
        @(negedge clk);
        xact(1, 0, 32'h0, '0, 4'h0, 1, 0, rd, e, ak);
        c0 = cyc;
        chk("b2b_first", 1, rd, mem[1][0]);
        xact(1, 0, 32'h4, '0, 4'h0, 0, 0, rd, e, ak);
        c1 = cyc;
        chk("b2b_gap", 1, c1 - c0, 2);
        chk("b2b_second", 1, rd, mem[1][1]);
        xact(1, 1, 32'(4 * D1), 32'h5555_AAAA, 4'hF, 0, 0, rd, e, ak);
        chk("w0_range_err", 1, e, 1);

        pend = 0;
        dsel = 0;
        for (int i = 0; i < 300; i++) begin
            if (!pend) dsel = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 7)       ra = 32'($urandom_range(0, (dsel == 0) ? 63 : 15) * 4);
            else if (r == 7) ra = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 8) ra = 32'((depth_of(dsel) + $urandom_range(0, 7)) * 4);
            else             ra = $urandom;
            keep = ($urandom_range(0, 3) == 0);
            xact(dsel, 1'($urandom), ra, $urandom, 4'($urandom), keep,
                 1'($urandom), rd, e, ak);
            pend = keep;
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req[0] = 0; req[1] = 0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
